// File: rtl/aes_host_pkg.sv
// Shared definitions for the AES APB host interface: register map,
// CR/SR bit positions, mode encodings and the host FSM state type.
package aes_host_pkg;

    // Word addresses of the register map
    localparam int A_CR    = 0;
    localparam int A_SR    = 1;
    localparam int A_DINR  = 2;
    localparam int A_DOUTR = 3;
    localparam int A_KEYR0 = 4;
    localparam int A_IVR0  = 8;
    localparam int A_LAST  = 11;

    // CR bit positions (MODE and CHMOD are 2-bit fields starting here)
    localparam int CR_EN       = 0;
    localparam int CR_MODE_LO  = 3;
    localparam int CR_CHMOD_LO = 5;
    localparam int CR_CCFC     = 7;
    localparam int CR_ERRC     = 8;
    localparam int CR_CCFIE    = 9;
    localparam int CR_ERRIE    = 10;

    // SR bit positions
    localparam int SR_CCF   = 0;
    localparam int SR_RDERR = 1;
    localparam int SR_WRERR = 2;

    // Operation mode (CR.MODE)
    typedef enum logic [1:0] {
        OP_ENC        = 2'b00,
        OP_KEYDER     = 2'b01,
        OP_DEC        = 2'b10,
        OP_KEYDER_DEC = 2'b11
    } op_mode_t;

    // Chaining mode (CR.CHMOD); 11 is reserved
    typedef enum logic [1:0] {
        CH_ECB = 2'b00,
        CH_CBC = 2'b01,
        CH_CTR = 2'b10
    } chain_mode_t;

    // Host sequencing FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_BUSY = 2'b10,
        ST_DONE = 2'b11
    } host_state_t;

endpackage

// File: rtl/aes_host_regs.sv
// KEYR0-3 / IVR0-3 register bank. Software writes are blocked while the
// core is enabled; the derived key from the control unit bypasses the lock.
module aes_host_regs
    import aes_host_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,          // write strobe, already decoded to addresses 4..11
    input  logic         lock,           // CR.EN: blocks software writes
    input  logic [2:0]   idx,            // word index within the bank (0..3 key, 4..7 iv)
    input  logic [31:0]  wdata,
    output logic [31:0]  rd_data,
    input  logic         key_load,       // load derived key into KEYR3..0
    input  logic [127:0] key_load_data,
    output logic [127:0] key_o,          // {KEYR3,KEYR2,KEYR1,KEYR0}
    output logic [127:0] iv_o            // {IVR3,IVR2,IVR1,IVR0}
);

    localparam int KEY_WORDS = A_IVR0 - A_KEYR0;

    logic [31:0] bank_q [8];

    // Bank update: derived-key load has priority over software writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (key_load && (i < KEY_WORDS)) begin
                    bank_q[i] <= key_load_data[32*i +: 32];
                end else if (wr_en && !lock && (idx == 3'(i))) begin
                    bank_q[i] <= wdata;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_flat
            assign key_o[32*gi +: 32] = bank_q[gi];
            assign iv_o[32*gi +: 32]  = bank_q[gi + KEY_WORDS];
        end
    endgenerate

    assign rd_data = bank_q[idx];

endmodule

// File: rtl/aes_apb_host_if.sv
// APB slave front end for the AES round control unit: register map,
// 128-bit block assembly, start sequencing, result read-out and flags.
module aes_apb_host_if
    import aes_host_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              start,
    output logic [1:0]        operation_mode,
    output logic [1:0]        aes_mode,
    output logic              disable_core,
    output logic [127:0]      data_in,
    output logic [127:0]      key_in,
    output logic [127:0]      iv_in,
    input  logic              end_comp,
    input  logic              key_derivation_en,
    input  logic [127:0]      data_out,
    input  logic [127:0]      key_out,
    output logic              irq_ccf,
    output logic              irq_err
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("aes_apb_host_if: DATA_W must be 32");
        end
        if (ADDR_W < 4) begin : g_bad_addr_w
            $error("aes_apb_host_if: ADDR_W must be at least 4");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] ADDR_CR    = ADDR_W'(A_CR);
    localparam logic [ADDR_W-1:0] ADDR_SR    = ADDR_W'(A_SR);
    localparam logic [ADDR_W-1:0] ADDR_DINR  = ADDR_W'(A_DINR);
    localparam logic [ADDR_W-1:0] ADDR_DOUTR = ADDR_W'(A_DOUTR);
    localparam logic [ADDR_W-1:0] ADDR_KEYR0 = ADDR_W'(A_KEYR0);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(A_LAST);

    // APB decode
    logic acc, wr, rd, addr_ok;
    logic wr_cr, wr_dinr, rd_doutr, wr_bank;
    logic [2:0] bank_idx;

    assign acc      = psel & penable;
    assign wr       = acc & pwrite;
    assign rd       = acc & ~pwrite;
    assign addr_ok  = (paddr <= ADDR_LAST);
    assign wr_cr    = wr & (paddr == ADDR_CR);
    assign wr_dinr  = wr & (paddr == ADDR_DINR);
    assign rd_doutr = rd & (paddr == ADDR_DOUTR);
    assign wr_bank  = wr & addr_ok & (paddr >= ADDR_KEYR0);
    assign bank_idx = 3'(paddr - ADDR_KEYR0);

    // State
    host_state_t  state_q, state_d;
    logic [1:0]   wc_q, wc_d;
    logic         start_q, start_d;
    logic [127:0] din_q, din_d;
    logic [127:0] dout_q, dout_d;
    logic         en_q, en_d;
    logic [1:0]   mode_q, mode_d;
    logic [1:0]   chmod_q, chmod_d;
    logic         ccfie_q, ccfie_d;
    logic         errie_q, errie_d;
    logic         ccf_q, ccf_d;
    logic         rderr_q, rderr_d;
    logic         wrerr_q, wrerr_d;
    logic         ccf_set, rderr_set, wrerr_set, key_load;

    logic [31:0]  bank_rd;
    logic [31:0]  dout_word;

    aes_host_regs u_regs (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_bank),
        .lock          (en_q),
        .idx           (bank_idx),
        .wdata         (pwdata),
        .rd_data       (bank_rd),
        .key_load      (key_load),
        .key_load_data (key_out),
        .key_o         (key_in),
        .iv_o          (iv_in)
    );

    // Select the output word pointed to by the word counter (MSW first)
    always_comb begin
        dout_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (wc_q == 2'(i)) begin
                dout_word = dout_q[127-32*i -: 32];
            end
        end
    end

    // Next-state logic: CR fields, FSM, word counter, block registers, flags
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        start_d   = 1'b0;
        din_d     = din_q;
        dout_d    = dout_q;
        en_d      = en_q;
        mode_d    = mode_q;
        chmod_d   = chmod_q;
        ccfie_d   = ccfie_q;
        errie_d   = errie_q;
        ccf_set   = 1'b0;
        rderr_set = 1'b0;
        wrerr_set = 1'b0;
        key_load  = 1'b0;

        // EN and interrupt enables are always writable; modes only while disabled
        if (wr_cr) begin
            en_d    = pwdata[CR_EN];
            ccfie_d = pwdata[CR_CCFIE];
            errie_d = pwdata[CR_ERRIE];
            if (!en_q) begin
                mode_d  = pwdata[CR_MODE_LO +: 2];
                chmod_d = pwdata[CR_CHMOD_LO +: 2];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_cr && pwdata[CR_EN]) begin
                    wc_d = 2'd0;
                    // Pure key derivation needs no data block
                    if (mode_d == OP_KEYDER) begin
                        start_d = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_dinr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wc_q == 2'(i)) begin
                            din_d[127-32*i -: 32] = pwdata;
                        end
                    end
                    if (wc_q == 2'd3) begin
                        start_d = 1'b1;
                        wc_d    = 2'd0;
                        state_d = ST_BUSY;
                    end else begin
                        wc_d = wc_q + 2'd1;
                    end
                end
                if (rd_doutr) begin
                    rderr_set = 1'b1;
                end
            end
            ST_BUSY: begin
                if (wr_dinr) begin
                    wrerr_set = 1'b1;
                end
                if (rd_doutr) begin
                    rderr_set = 1'b1;
                end
                if (end_comp) begin
                    ccf_set = 1'b1;
                    wc_d    = 2'd0;
                    if (key_derivation_en) begin
                        key_load = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        dout_d  = data_out;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (wr_dinr) begin
                    wrerr_set = 1'b1;
                end
                if (rd_doutr) begin
                    if (wc_q == 2'd3) begin
                        wc_d    = 2'd0;
                        state_d = ST_LOAD;
                    end else begin
                        wc_d = wc_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling the core aborts any operation in progress
        if (!en_d) begin
            state_d = ST_IDLE;
            wc_d    = 2'd0;
            start_d = 1'b0;
        end
    end

    // Flags: a new event in the same cycle as its clear request wins
    assign ccf_d   = (ccf_q   & ~(wr_cr & pwdata[CR_CCFC])) | ccf_set;
    assign rderr_d = (rderr_q & ~(wr_cr & pwdata[CR_ERRC])) | rderr_set;
    assign wrerr_d = (wrerr_q & ~(wr_cr & pwdata[CR_ERRC])) | wrerr_set;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wc_q    <= 2'd0;
            start_q <= 1'b0;
            din_q   <= '0;
            dout_q  <= '0;
            en_q    <= 1'b0;
            mode_q  <= 2'd0;
            chmod_q <= 2'd0;
            ccfie_q <= 1'b0;
            errie_q <= 1'b0;
            ccf_q   <= 1'b0;
            rderr_q <= 1'b0;
            wrerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            start_q <= start_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            chmod_q <= chmod_d;
            ccfie_q <= ccfie_d;
            errie_q <= errie_d;
            ccf_q   <= ccf_d;
            rderr_q <= rderr_d;
            wrerr_q <= wrerr_d;
        end
    end

    // Read mux: valid only during a read access phase to a mapped address
    always_comb begin
        prdata = '0;
        if (rd && addr_ok) begin
            case (paddr)
                ADDR_CR: begin
                    prdata[CR_EN]              = en_q;
                    prdata[CR_MODE_LO +: 2]    = mode_q;
                    prdata[CR_CHMOD_LO +: 2]   = chmod_q;
                    prdata[CR_CCFIE]           = ccfie_q;
                    prdata[CR_ERRIE]           = errie_q;
                end
                ADDR_SR: begin
                    prdata[SR_CCF]   = ccf_q;
                    prdata[SR_RDERR] = rderr_q;
                    prdata[SR_WRERR] = wrerr_q;
                end
                ADDR_DINR: prdata = '0;
                ADDR_DOUTR: begin
                    if (state_q == ST_DONE) begin
                        prdata = dout_word;
                    end
                end
                default: prdata = bank_rd;
            endcase
        end
    end

    assign pready         = 1'b1;
    assign pslverr        = acc & ~addr_ok;
    assign start          = start_q;
    assign operation_mode = mode_q;
    assign aes_mode       = chmod_q;
    assign disable_core   = ~en_q;
    assign data_in        = din_q;
    assign irq_ccf        = ccf_q & ccfie_q;
    assign irq_err        = (rderr_q | wrerr_q) & errie_q;

endmodule

// File: tb/tb_aes_apb_host_if.sv
// Scoreboard bench for aes_apb_host_if: stimulus pushes expected read data
// and start events into queues; a monitor pops and compares them.
module tb_aes_apb_host_if;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]   paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [31:0]  prdata;
    logic         pready, pslverr, start, disable_core;
    logic [1:0]   operation_mode, aes_mode;
    logic [127:0] data_in, key_in, iv_in;
    logic         end_comp = 1'b0, key_derivation_en = 1'b0;
    logic [127:0] data_out = '0, key_out = '0;
    logic         irq_ccf, irq_err;

    aes_apb_host_if #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .psel              (psel),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .prdata            (prdata),
        .pready            (pready),
        .pslverr           (pslverr),
        .start             (start),
        .operation_mode    (operation_mode),
        .aes_mode          (aes_mode),
        .disable_core      (disable_core),
        .data_in           (data_in),
        .key_in            (key_in),
        .iv_in             (iv_in),
        .end_comp          (end_comp),
        .key_derivation_en (key_derivation_en),
        .data_out          (data_out),
        .key_out           (key_out),
        .irq_ccf           (irq_ccf),
        .irq_err           (irq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Scoreboard queues
    string        exp_rd_name[$];
    logic [31:0]  exp_rd_data[$];
    logic         exp_rd_err[$];
    int           exp_st_cyc[$];
    logic         exp_st_chk[$];
    logic [127:0] exp_st_din[$];
    logic [1:0]   exp_st_opm[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    // Monitor: compares every read access phase and every start pulse
    always @(negedge clk) begin : monitor
        string        nm;
        logic [31:0]  d;
        logic         e;
        int           c;
        logic         ck;
        logic [127:0] din;
        logic [1:0]   opm;
        if (rst_n && psel && penable && !pwrite) begin
            if (exp_rd_data.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_read: addr %0d prdata %h, required no read", paddr, prdata);
            end else begin
                nm = exp_rd_name.pop_front();
                d  = exp_rd_data.pop_front();
                e  = exp_rd_err.pop_front();
                chk(nm, prdata, d);
                chk({nm, "_slverr"}, 32'(pslverr), 32'(e));
            end
        end
        if (rst_n && start) begin
            if (exp_st_cyc.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_start: start=1 at cycle %0d, required 0", cyc);
            end else begin
                c   = exp_st_cyc.pop_front();
                ck  = exp_st_chk.pop_front();
                din = exp_st_din.pop_front();
                opm = exp_st_opm.pop_front();
                chk("start_cycle", 32'(cyc), 32'(c));
                chk("start_opmode", 32'(operation_mode), 32'(opm));
                if (ck) chk128("start_data_in", data_in, din);
            end
        end
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("[TB] write addr %0d data %h", a, d);
    endtask

    task automatic apb_read(input logic [3:0] a, input logic [31:0] exp, input logic err, input string name);
        exp_rd_name.push_back(name);
        exp_rd_data.push_back(exp);
        exp_rd_err.push_back(err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Expect start in the cycle right after the write that just committed
    task automatic expect_start(input logic ck, input logic [127:0] din, input logic [1:0] opm);
        exp_st_cyc.push_back(cyc);
        exp_st_chk.push_back(ck);
        exp_st_din.push_back(din);
        exp_st_opm.push_back(opm);
    endtask

    task automatic pulse_end(input logic [127:0] dout, input logic kd, input logic [127:0] kout);
        @(posedge clk); #1;
        end_comp = 1'b1; key_derivation_en = kd; data_out = dout; key_out = kout;
        @(posedge clk); #1;
        end_comp = 1'b0; key_derivation_en = 1'b0;
        $display("[TB] end_comp data_out %h kd %0d", dout, kd);
    endtask

    // APB write whose access phase coincides with end_comp
    task automatic write_with_end(input logic [3:0] a, input logic [31:0] d, input logic [127:0] dout);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; end_comp = 1'b1; data_out = dout;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; end_comp = 1'b0;
        $display("[TB] write addr %0d data %h with end_comp", a, d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_disable_core", 32'(disable_core), 32'd1);
        chk("rst_irq_ccf", 32'(irq_ccf), 32'd0);
        chk("rst_irq_err", 32'(irq_err), 32'd0);
        chk("rst_pready", 32'(pready), 32'd1);
        apb_read(4'd0, 32'h0, 1'b0, "rst_cr");
        apb_read(4'd1, 32'h0, 1'b0, "rst_sr");

        // Key/IV setup with EN=0
        apb_write(4'd4, 32'h09CF4F3C);
        apb_write(4'd5, 32'hABF71588);
        apb_write(4'd6, 32'h28AED2A6);
        apb_write(4'd7, 32'h2B7E1516);
        apb_write(4'd8, 32'h03020100);
        apb_read(4'd4, 32'h09CF4F3C, 1'b0, "keyr0_rd");
        apb_read(4'd8, 32'h03020100, 1'b0, "ivr0_rd");
        chk128("key_in", key_in, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C);

        // ECB encrypt
        apb_write(4'd0, 32'h001);
        chk("en_disable_core", 32'(disable_core), 32'd0);
        apb_write(4'd2, 32'h00112233);
        apb_write(4'd2, 32'h44556677);
        apb_write(4'd2, 32'h8899AABB);
        apb_write(4'd2, 32'hCCDDEEFF);
        expect_start(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b00);
        pulse_end(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 1'b0, '0);
        apb_read(4'd1, 32'h1, 1'b0, "ecb_sr");
        apb_read(4'd3, 32'h69C4E0D8, 1'b0, "ecb_dout0");
        apb_read(4'd3, 32'h6A7B0430, 1'b0, "ecb_dout1");
        apb_read(4'd3, 32'hD8CDB780, 1'b0, "ecb_dout2");
        apb_read(4'd3, 32'h70B4C55A, 1'b0, "ecb_dout3");

        // Write lock while EN=1
        apb_write(4'd4, 32'hDEADBEEF);
        apb_read(4'd4, 32'h09CF4F3C, 1'b0, "lock_keyr0");
        apb_write(4'd0, 32'h011);
        apb_read(4'd0, 32'h001, 1'b0, "lock_cr_mode");
        apb_write(4'd0, 32'h081);
        apb_read(4'd1, 32'h0, 1'b0, "ccfc_sr");

        // Errors: DINR write in BUSY, DOUTR read in LOAD
        apb_write(4'd0, 32'h401);
        apb_read(4'd0, 32'h401, 1'b0, "errie_cr");
        apb_write(4'd2, 32'hA0A0A0A0);
        apb_write(4'd2, 32'hB0B0B0B0);
        apb_write(4'd2, 32'hC0C0C0C0);
        apb_write(4'd2, 32'hD0D0D0D0);
        expect_start(1'b1, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0, 2'b00);
        apb_write(4'd2, 32'h12345678);
        apb_read(4'd1, 32'h4, 1'b0, "busy_wrerr_sr");
        chk("irq_err_set", 32'(irq_err), 32'd1);
        pulse_end(128'h11112222_33334444_55556666_77778888, 1'b0, '0);
        apb_read(4'd3, 32'h11112222, 1'b0, "err_dout0");
        apb_read(4'd3, 32'h33334444, 1'b0, "err_dout1");
        apb_read(4'd3, 32'h55556666, 1'b0, "err_dout2");
        apb_read(4'd3, 32'h77778888, 1'b0, "err_dout3");
        apb_read(4'd3, 32'h0, 1'b0, "load_doutr");
        apb_read(4'd1, 32'h7, 1'b0, "load_rderr_sr");
        apb_write(4'd0, 32'h581);
        apb_read(4'd1, 32'h0, 1'b0, "errc_sr");
        chk("irq_err_clr", 32'(irq_err), 32'd0);
        apb_read(4'd0, 32'h401, 1'b0, "cr_pulses_read0");

        // Abort after 2 words, then a fresh 4-word load
        apb_write(4'd2, 32'h01010101);
        apb_write(4'd2, 32'h02020202);
        apb_write(4'd0, 32'h000);
        chk("abort_disable_core", 32'(disable_core), 32'd1);
        apb_write(4'd0, 32'h001);
        apb_write(4'd2, 32'h31313131);
        apb_write(4'd2, 32'h32323232);
        apb_write(4'd2, 32'h33333333);
        apb_write(4'd2, 32'h34343434);
        expect_start(1'b1, 128'h31313131_32323232_33333333_34343434, 2'b00);
        pulse_end(128'h0, 1'b0, '0);
        apb_write(4'd0, 32'h000);
        apb_write(4'd0, 32'h080);
        apb_read(4'd1, 32'h0, 1'b0, "idle_ccfc_sr");

        // Key derivation
        apb_write(4'd0, 32'h009);
        expect_start(1'b0, '0, 2'b01);
        chk("kd_opmode", 32'(operation_mode), 32'd1);
        pulse_end('0, 1'b1, 128'h13111D7F_E3944A17_F307A78B_4D2B30C5);
        apb_read(4'd7, 32'h13111D7F, 1'b0, "kd_keyr3");
        apb_read(4'd6, 32'hE3944A17, 1'b0, "kd_keyr2");
        apb_read(4'd4, 32'h4D2B30C5, 1'b0, "kd_keyr0");
        apb_read(4'd1, 32'h1, 1'b0, "kd_sr");

        // CCFC racing end_comp
        apb_write(4'd0, 32'h089);
        apb_read(4'd1, 32'h0, 1'b0, "race_pre_sr");
        apb_write(4'd2, 32'h00000001);
        apb_write(4'd2, 32'h00000002);
        apb_write(4'd2, 32'h00000003);
        apb_write(4'd2, 32'h00000004);
        expect_start(1'b1, 128'h00000001_00000002_00000003_00000004, 2'b01);
        write_with_end(4'd0, 32'h089, 128'h5);
        apb_read(4'd1, 32'h1, 1'b0, "race_sr");
        apb_write(4'd0, 32'h089);
        apb_read(4'd1, 32'h0, 1'b0, "race_clr_sr");

        // Unmapped address
        apb_read(4'd12, 32'h0, 1'b1, "slverr_rd");

        repeat (4) @(posedge clk);
        #1;
        while (exp_rd_data.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL missing_read %s: got no read, required %h", exp_rd_name.pop_front(), exp_rd_data.pop_front());
        end
        while (exp_st_cyc.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL missing_start: got none, required start at cycle %0d", exp_st_cyc.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
